// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: opcodes, FSM state encodings,
// immediate-extender and ALU operation codes, and the decoded-instruction record.
package cpu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EXE_A = 4'd2,
        S_EXE_B = 4'd3,
        S_EXE_L = 4'd4,
        S_MEM   = 4'd5,
        S_WB_A  = 4'd6,
        S_WB_L  = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    localparam logic [1:0] EXT_ZERO5  = 2'b00;  // shamt field [15:11]
    localparam logic [1:0] EXT_ZERO16 = 2'b01;
    localparam logic [1:0] EXT_SIGN   = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef struct packed {
        logic       alu;      // goes through EXE_A / WB_A
        logic       branch;   // beq
        logic       mem;      // lw or sw
        logic       lw;
        logic       sw;
        logic       halt;
        logic       fin_id;   // retires in ID: j, jr, jal, illegal
        logic       pc_jump;  // j or jal
        logic       jr;
        logic       jal;
        logic       rtype;
        logic       src_a;
        logic       src_b;
        logic [1:0] ext_sel;
        logic [2:0] alu_op;
    } dec_t;

endpackage

// File: rtl/op_decode.sv
// Opcode decoder: maps the 6-bit opcode onto instruction-class flags and the
// opcode-only control fields. Unknown opcodes decode as retire-in-ID.
module op_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output dec_t       dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch behind.
        dec         = '0;
        dec.ext_sel = EXT_SIGN;
        dec.alu_op  = ALU_ADD;
        unique case (opcode)
            OP_ADD:  begin dec.alu = 1'b1; dec.rtype = 1'b1; end
            OP_SUB:  begin dec.alu = 1'b1; dec.rtype = 1'b1; dec.alu_op = ALU_SUB; end
            OP_ADDI: begin dec.alu = 1'b1; dec.src_b = 1'b1; end
            OP_OR:   begin dec.alu = 1'b1; dec.rtype = 1'b1; dec.alu_op = ALU_OR; end
            OP_AND:  begin dec.alu = 1'b1; dec.rtype = 1'b1; dec.alu_op = ALU_AND; end
            OP_ORI:  begin
                dec.alu     = 1'b1;
                dec.src_b   = 1'b1;
                dec.ext_sel = EXT_ZERO16;
                dec.alu_op  = ALU_OR;
            end
            OP_SLL:  begin
                dec.alu     = 1'b1;
                dec.rtype   = 1'b1;
                dec.src_a   = 1'b1;
                dec.src_b   = 1'b1;
                dec.ext_sel = EXT_ZERO5;
                dec.alu_op  = ALU_SLL;
            end
            OP_SLT:  begin dec.alu = 1'b1; dec.rtype = 1'b1; dec.alu_op = ALU_SLT; end
            OP_SW:   begin dec.mem = 1'b1; dec.sw = 1'b1; dec.src_b = 1'b1; end
            OP_LW:   begin dec.mem = 1'b1; dec.lw = 1'b1; dec.src_b = 1'b1; end
            OP_BEQ:  begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
            OP_J:    begin dec.fin_id = 1'b1; dec.pc_jump = 1'b1; end
            OP_JR:   begin dec.fin_id = 1'b1; dec.jr = 1'b1; end
            OP_JAL:  begin dec.fin_id = 1'b1; dec.pc_jump = 1'b1; dec.jal = 1'b1; end
            OP_HALT: dec.halt = 1'b1;
            default: dec.fin_id = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM (Moore). Defining CONTROL_UNIT_RETIRE_CNT_EN adds
// the RetireCnt output counting retired instructions.
module control_unit
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  OpCode,
    input  logic        Zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        RegWre,
    output logic        WrRegDst,
    output logic        DataMemRW,
    output logic        DBDataSrc,
    output logic        Halted,
    output logic [1:0]  ExtSel,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSrc,
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    output logic [31:0] RetireCnt,
`endif
    output logic [3:0]  State
);

    state_t state;
    dec_t   dec_live;
    dec_t   dec_q;
    dec_t   cur;

    op_decode u_dec (
        .opcode (OpCode),
        .dec    (dec_live)
    );

    // Decode is sampled in ID and frozen for the rest of the instruction.
    assign cur   = (state == S_ID) ? dec_live : dec_q;
    assign State = state;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IF;
            dec_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            if (state == S_ID)
                dec_q <= dec_live;
            unique case (state)
                S_IF:    state <= S_ID;
                S_ID: begin
                    if (cur.alu)         state <= S_EXE_A;
                    else if (cur.branch) state <= S_EXE_B;
                    else if (cur.mem)    state <= S_EXE_L;
                    else if (cur.halt)   state <= S_HALT;
                    else                 state <= S_IF;
                end
                S_EXE_A: state <= S_WB_A;
                S_EXE_B: state <= S_IF;
                S_EXE_L: state <= S_MEM;
                S_MEM:   state <= cur.lw ? S_WB_L : S_IF;
                S_WB_A:  state <= S_IF;
                S_WB_L:  state <= S_IF;
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        RegWre    = 1'b0;
        WrRegDst  = 1'b0;
        DataMemRW = 1'b0;
        DBDataSrc = 1'b0;
        Halted    = 1'b0;
        ExtSel    = EXT_SIGN;
        ALUOp     = ALU_ADD;
        PCSrc     = 2'b00;
        if (state == S_IF) begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
        end else if (state == S_HALT) begin
            Halted = 1'b1;
        end else begin
            ALUSrcA   = cur.src_a;
            ALUSrcB   = cur.src_b;
            WrRegDst  = cur.rtype;
            DBDataSrc = cur.lw;
            ExtSel    = cur.ext_sel;
            ALUOp     = cur.alu_op;
            if (cur.pc_jump)
                PCSrc = 2'b11;
            else if (cur.jr)
                PCSrc = 2'b10;
            else if (state == S_EXE_B && Zero)
                PCSrc = 2'b01;
            unique case (state)
                S_ID: begin
                    PCWre  = cur.fin_id;
                    RegWre = cur.jal;
                end
                S_EXE_B: PCWre = 1'b1;
                S_MEM: begin
                    PCWre     = cur.sw;
                    DataMemRW = cur.sw;
                end
                S_WB_A, S_WB_L: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            retire_cnt <= '0;
        else if (PCWre && state != S_HALT)
            retire_cnt <= retire_cnt + 32'd1;
    end

    assign RetireCnt = retire_cnt;
`endif

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide port OpCode  input  6  instruction bits [31:26] from IR, held stable by IR after IF.
REQ-004 SHALL provide port Zero  input  1  ALU zero flag.
REQ-005 SHALL provide outputs, 1 bit each: PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, RegWre, WrRegDst, DataMemRW, DBDataSrc, Halted.
REQ-006 SHALL provide outputs ExtSel[1:0] (immediate-extender select), ALUOp[2:0], PCSrc[1:0] and State[3:0].

Function
REQ-007 SHALL decode opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111; any other opcode is illegal.
REQ-008 SHALL implement Moore states IF, ID, EXE_A, EXE_B, EXE_L, MEM, WB_A, WB_L, HALT.
REQ-009 SHALL transition: IF->ID always; ID->EXE_A (add, sub, addi, or, and, ori, sll, slt), ID->EXE_B (beq), ID->EXE_L (lw, sw), ID->HALT (halt), ID->IF (j, jr, jal, illegal).
REQ-010 SHALL transition: EXE_A->WB_A, EXE_B->IF, EXE_L->MEM, MEM->WB_L (lw), MEM->IF (sw), WB_A->IF, WB_L->IF; HALT holds until Reset.
REQ-011 SHALL assert IRWre=1 and InsMemRW=1 only in IF.
REQ-012 SHALL assert PCWre=1 exactly in each instruction's final cycle: ID for j/jr/jal/illegal, EXE_B, MEM for sw, WB_A, WB_L; never in HALT.
REQ-013 SHALL drive PCSrc: 11 for j/jal, 10 for jr, 01 in EXE_B when Zero=1, 00 otherwise.
REQ-014 SHALL drive ExtSel: 00 for sll (zero-extend [15:11]), 01 for ori (zero-extend 16 bits), 10 for all other opcodes (sign-extend).
REQ-015 SHALL drive ALUSrcA=1 only for sll; ALUSrcB=1 for addi, ori, sll, lw, sw.
REQ-016 SHALL drive ALUOp: add/addi/lw/sw 000, sub/beq 001, or/ori 011, and 100, sll 010, slt 110; 000 for others.
REQ-017 SHALL assert RegWre=1 in WB_A, in WB_L, and in ID for jal; 0 elsewhere.
REQ-018 SHALL drive WrRegDst=1 for R-type writes (add, sub, or, and, sll, slt), 0 otherwise; jal's register 31 destination is handled by the datapath.
REQ-019 SHALL assert DataMemRW=1 only in MEM for sw; DBDataSrc=1 only for lw.
REQ-020 SHALL assert Halted=1 while in HALT, and expose the current state encoding on State.
REQ-021 SHALL generate all outputs combinationally from the registered state, OpCode and Zero; OpCode changes are ignored except in ID.

Reset
REQ-022 SHALL, on Reset=0, asynchronously force state IF and the retire counter (if present) to 0.
REQ-023 SHALL hold reset output values: IRWre=1, InsMemRW=1, every other 1-bit output 0, ExtSel=10, ALUOp=000, PCSrc=00.
REQ-024 SHALL abandon any in-flight instruction on mid-operation reset, and SHALL start IF on the first rising edge after Reset deasserts.

Configuration
REQ-025 SHALL, when CONTROL_UNIT_RETIRE_CNT_EN is defined, add output RetireCnt[31:0] that increments by 1 each cycle PCWre=1, wraps from 0xFFFFFFFF to 0, and stops in HALT.
REQ-026 SHALL, when CONTROL_UNIT_RETIRE_CNT_EN is undefined, omit RetireCnt and its counter register entirely.

Structure
REQ-027 SHALL place opcode constants, state encodings (IF=0000 through HALT=1000), ExtSel codes and ALUOp codes in shared package cpu_pkg.
REQ-028 SHALL implement decode as sub-module op_decode (OpCode -> instruction-class flags); the FSM and output logic remain in control_unit.

Verification
REQ-029 SHALL check: Reset low mid-EXE_L, then release -> State=IF asynchronously, IRWre=1, PCWre=0.
REQ-030 SHALL check: addi 000010 -> IF, ID, EXE_A, WB_A (4 cycles); ExtSel=10, ALUSrcB=1, RegWre=1 and PCWre=1 only in WB_A.
REQ-031 SHALL check: lw 110001 -> 5 cycles, DBDataSrc=1, RegWre=1 in WB_L; sw 110000 -> 4 cycles, DataMemRW=1 in MEM, RegWre never 1.
REQ-032 SHALL check: beq with Zero=1 -> PCSrc=01 in EXE_B; with Zero=0 -> PCSrc=00; ALUOp=001 in both.
REQ-033 SHALL check: sll -> ExtSel=00, ALUSrcA=1; ori -> ExtSel=01; illegal 101010 -> ID->IF with PCWre=1 and RegWre=0.
REQ-034 SHALL check: halt -> HALT persists 10 cycles with Halted=1 and PCWre=0; with the macro defined, RetireCnt is frozen and equals the retired instruction count.
